// File: rtl/preg_freelist_pkg.sv
// preg_freelist_pkg: shared sizes and pointer type for the physical-register free list
package preg_freelist_pkg;
  localparam int PREG_NUM = 64;
  localparam int LREG_NUM = 32;
  localparam int FREE_DEPTH = PREG_NUM - LREG_NUM;
  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int IDX_W = $clog2(FREE_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0] freelist_ptr_t;
  localparam freelist_ptr_t TAIL_RST = freelist_ptr_t'(FREE_DEPTH);
endpackage

// File: rtl/freelist_ptr.sv
// freelist_ptr: wrap-bit queue pointer advancing by 0..2, with a parallel load for rollback
module freelist_ptr
  import preg_freelist_pkg::*;
#(
  parameter freelist_ptr_t RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    inc,
  input  logic          load,
  input  freelist_ptr_t load_val,
  output freelist_ptr_t q
);
  always_ff @(posedge clk)
    q <= rst ? RST_VAL : load ? load_val : q + PTR_W'(inc);
endmodule

// File: rtl/preg_freelist.sv
// preg_freelist: rename-stage free list granting two prds per cycle, reclaiming on commit, rolling back on flush
module preg_freelist
  import preg_freelist_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              instr0_freelist_req,
  output logic [PREG_W-1:0] instr0_freelist_resp,
  input  logic              instr1_freelist_req,
  output logic [PREG_W-1:0] instr1_freelist_resp,
  output logic              freelist_stall,
  input  logic              commit0_valid,
  input  logic              commit0_need_to_wb,
  input  logic [PREG_W-1:0] commit0_old_prd,
  input  logic              commit1_valid,
  input  logic              commit1_need_to_wb,
  input  logic [PREG_W-1:0] commit1_old_prd,
  input  logic              redirect_flush,
  output logic [PREG_W-1:0] free_count
);
  preg_t entries [FREE_DEPTH];
  freelist_ptr_t spec_head, arch_head, tail, arch_next;
  logic [IDX_W-1:0] sh_idx, t_idx;
  logic [1:0] n, alloc_n, rel_n;
  logic rel0, rel1;
  always_comb begin
    rel0 = commit0_valid & commit0_need_to_wb;
    rel1 = commit1_valid & commit1_need_to_wb;
    rel_n = {1'b0, rel0} + {1'b0, rel1};
    n = {1'b0, instr0_freelist_req} + {1'b0, instr1_freelist_req};
    free_count = PREG_W'(tail - spec_head);
    freelist_stall = (free_count < PREG_W'(n)) & ~redirect_flush;
    alloc_n = (freelist_stall | redirect_flush) ? 2'd0 : n;
    arch_next = arch_head + PTR_W'(rel_n);
    sh_idx = spec_head[IDX_W-1:0];
    t_idx = tail[IDX_W-1:0];
    instr0_freelist_resp = entries[sh_idx];
    instr1_freelist_resp = entries[instr0_freelist_req ? sh_idx + IDX_W'(1) : sh_idx];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FREE_DEPTH; i++) entries[i] <= PREG_W'(LREG_NUM + i);
    end else begin
      if (rel0) entries[t_idx] <= commit0_old_prd;
      if (rel1) entries[t_idx + IDX_W'(rel0)] <= commit1_old_prd;
    end
  end
  // Flush rewinds to the committed point, counting commits retiring in the same cycle.
  freelist_ptr #(.RST_VAL('0)) u_spec_head (
    .clk(clock), .rst(reset), .inc(alloc_n), .load(redirect_flush), .load_val(arch_next), .q(spec_head)
  );
  freelist_ptr #(.RST_VAL('0)) u_arch_head (
    .clk(clock), .rst(reset), .inc(rel_n), .load(1'b0), .load_val('0), .q(arch_head)
  );
  freelist_ptr #(.RST_VAL(TAIL_RST)) u_tail (
    .clk(clock), .rst(reset), .inc(rel_n), .load(1'b0), .load_val('0), .q(tail)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(rel0 && commit0_old_prd == '0));
      assert (!(rel1 && commit1_old_prd == '0));
      assert (free_count <= PREG_W'(FREE_DEPTH));
      assert (PTR_W'(spec_head - arch_head) <= PTR_W'(tail - arch_head));
    end
  end
endmodule

// File: tb/tb_preg_freelist.sv
// tb_preg_freelist: directed and random checks of preg_freelist against a queue-based free-list model
module tb_preg_freelist;
  logic clock = 0, reset = 1;
  logic instr0_freelist_req = 0, instr1_freelist_req = 0;
  logic [5:0] instr0_freelist_resp, instr1_freelist_resp, free_count;
  logic freelist_stall;
  logic commit0_valid = 0, commit0_need_to_wb = 0, commit1_valid = 0, commit1_need_to_wb = 0;
  logic [5:0] commit0_old_prd = 0, commit1_old_prd = 0;
  logic redirect_flush = 0;
  int n_checks = 0, n_fail = 0;
  int fl[$];
  int alloc_q[$];

  preg_freelist dut (
    .clock(clock), .reset(reset),
    .instr0_freelist_req(instr0_freelist_req), .instr0_freelist_resp(instr0_freelist_resp),
    .instr1_freelist_req(instr1_freelist_req), .instr1_freelist_resp(instr1_freelist_resp),
    .freelist_stall(freelist_stall),
    .commit0_valid(commit0_valid), .commit0_need_to_wb(commit0_need_to_wb), .commit0_old_prd(commit0_old_prd),
    .commit1_valid(commit1_valid), .commit1_need_to_wb(commit1_need_to_wb), .commit1_old_prd(commit1_old_prd),
    .redirect_flush(redirect_flush), .free_count(free_count)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    instr0_freelist_req = 0; instr1_freelist_req = 0;
    commit0_valid = 0; commit0_need_to_wb = 0; commit0_old_prd = 0;
    commit1_valid = 0; commit1_need_to_wb = 0; commit1_old_prd = 0;
    redirect_flush = 0;
  endtask

  task automatic model_reset();
    fl.delete();
    alloc_q.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
  endtask

  task automatic do_reset(bit noisy);
    reset = 1;
    if (noisy) begin
      instr0_freelist_req = 1'($urandom); instr1_freelist_req = 1'($urandom);
      commit0_valid = 1'($urandom); commit0_need_to_wb = 1'($urandom); commit0_old_prd = 6'($urandom);
      commit1_valid = 1'($urandom); commit1_need_to_wb = 1'($urandom); commit1_old_prd = 6'($urandom);
      redirect_flush = 1'($urandom);
    end
    @(posedge clock); #1;
    reset = 0;
    idle();
    model_reset();
    #1;
  endtask

  // One cycle: drive, check combinational outputs against the model, then advance the model at the edge.
  task automatic step(input bit r0, r1, c0v, c0w, input int c0p, input bit c1v, c1w, input int c1p, input bit fls);
    int n;
    bit exp_stall, rel0, rel1;
    instr0_freelist_req = r0; instr1_freelist_req = r1;
    commit0_valid = c0v; commit0_need_to_wb = c0w; commit0_old_prd = 6'(c0p);
    commit1_valid = c1v; commit1_need_to_wb = c1w; commit1_old_prd = 6'(c1p);
    redirect_flush = fls;
    @(negedge clock);
    n = r0 + r1;
    exp_stall = (fl.size() < n) && !fls;
    check("free_count", free_count, fl.size());
    check("stall", freelist_stall, exp_stall);
    check("fc_bound", free_count <= 32, 1);
    if (!exp_stall && fl.size() > 0) check("resp0", instr0_freelist_resp, fl[0]);
    if (!exp_stall && r1 && fl.size() > r0) check("resp1", instr1_freelist_resp, fl[r0]);
    rel0 = c0v && c0w;
    rel1 = c1v && c1w;
    if (!fls && !exp_stall) repeat (n) alloc_q.push_back(fl.pop_front());
    if (rel0) begin void'(alloc_q.pop_front()); fl.push_back(c0p); end
    if (rel1) begin void'(alloc_q.pop_front()); fl.push_back(c1p); end
    if (fls) begin
      fl = {alloc_q, fl};
      alloc_q.delete();
    end
    @(posedge clock); #1;
    idle();
    #1;
  endtask

  initial begin
    bit r0, r1, c0v, c0w, c1v, c1w, f;
    int avail;
    idle();
    do_reset(0);
    check("rst_fc", free_count, 32);
    check("rst_stall", freelist_stall, 0);
    check("rst_resp0", instr0_freelist_resp, 32);
    instr0_freelist_req = 1; #1;
    check("rst_resp1", instr1_freelist_resp, 33);
    idle();

    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("dual_fc", free_count, 30);
    check("dual_resp0", instr0_freelist_resp, 34);
    instr0_freelist_req = 1; #1;
    check("dual_resp1", instr1_freelist_resp, 35);
    idle();
    repeat (15) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("empty_fc", free_count, 0);
    step(1, 0, 1, 1, 5, 0, 0, 0, 0);
    check("refill_fc", free_count, 1);
    check("refill_resp0", instr0_freelist_resp, 5);
    instr0_freelist_req = 1; #1;
    check("refill_stall", freelist_stall, 0);
    idle();

    do_reset(0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("i1_fc", free_count, 31);
    check("i1_resp0", instr0_freelist_resp, 33);

    do_reset(0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 7, 1, 1, 9, 0);
    check("commit_fc", free_count, 30);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("flush_fc", free_count, 32);
    check("flush_resp0", instr0_freelist_resp, 34);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 11, 0, 0, 0, 1);
    check("flushreq_fc", free_count, 32);
    check("flushreq_resp0", instr0_freelist_resp, 35);

    for (int i = 0; i < 600; i++) begin
      avail = alloc_q.size();
      r0 = 1'($urandom); r1 = 1'($urandom);
      c0v = 1'($urandom); c0w = $urandom_range(0, 3) != 0;
      if (c0v && c0w && avail == 0) c0w = 0;
      if (c0v && c0w) avail--;
      c1v = 1'($urandom); c1w = $urandom_range(0, 3) != 0;
      if (c1v && c1w && avail == 0) c1w = 0;
      f = $urandom_range(0, 19) == 0;
      step(r0, r1, c0v, c0w, $urandom_range(1, 63), c1v, c1w, $urandom_range(1, 63), f);
    end

    do_reset(1);
    check("midrst_fc", free_count, 32);
    check("midrst_resp0", instr0_freelist_resp, 32);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
